// File: rtl/plab5_mcore_dma_cmd_queue.sv
// Command queue in front of a single-outstanding DMA controller: buffers core copy
// commands in a FIFO, holds one debug request, and returns one completion per operation.
module plab5_mcore_dma_cmd_queue #(
  parameter int p_addr_nbits  = 32,
  parameter int p_data_nbits  = 32,
  parameter int p_tag_nbits   = 4,
  parameter int p_num_entries = 4,
  parameter int p_timeout     = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_val,
  output logic                    cmd_rdy,
  input  logic [p_addr_nbits-1:0] cmd_src_addr,
  input  logic [p_addr_nbits-1:0] cmd_dest_addr,
  input  logic [p_tag_nbits-1:0]  cmd_tag,
  input  logic                    db_val,
  output logic                    db_rdy,
  input  logic [p_addr_nbits-1:0] db_src_addr,
  input  logic [p_addr_nbits-1:0] db_dest_addr,
  input  logic                    db_inst,
  output logic                    dma_val,
  output logic                    dma_db_val,
  input  logic                    dma_rdy,
  output logic [p_addr_nbits-1:0] dma_src_addr,
  output logic [p_addr_nbits-1:0] dma_dest_addr,
  output logic [p_addr_nbits-1:0] dma_db_src_addr,
  output logic [p_addr_nbits-1:0] dma_db_dest_addr,
  output logic                    dma_db_inst,
  input  logic                    dma_ack,
  input  logic [p_data_nbits-1:0] dma_debug_data,
  output logic                    done_val,
  input  logic                    done_rdy,
  output logic [p_tag_nbits-1:0]  done_tag,
  output logic                    done_debug,
  output logic                    done_err,
  output logic [p_data_nbits-1:0] done_data
);

  // state    | meaning
  // IDLE     | nothing in flight; pick debug slot first, else FIFO head
  // ISSUE    | presenting selected request to the DMA until dma_rdy
  // WAIT_ACK | one operation outstanding; counting cycles toward timeout
  // RESP     | completion presented until done_rdy
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (p_timeout > 1) ? $clog2(p_timeout + 1) : 1;
  localparam logic [CW-1:0] NUM   = CW'(p_num_entries);
  localparam logic [TW-1:0] TLAST = TW'(p_timeout - 1);

  state_t state, state_nxt;

  logic [p_addr_nbits-1:0] q_src  [p_num_entries];
  logic [p_addr_nbits-1:0] q_dest [p_num_entries];
  logic [p_tag_nbits-1:0]  q_tag  [p_num_entries];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rdy_en;

  logic                    db_full, db_inst_q;
  logic [p_addr_nbits-1:0] db_src_q, db_dest_q;

  logic                    cur_debug, cur_inst;
  logic [p_addr_nbits-1:0] cur_src, cur_dest;
  logic [p_tag_nbits-1:0]  cur_tag;
  logic [TW-1:0]           timer;
  logic                    err_q;
  logic [p_data_nbits-1:0] data_q;

  logic enq, deq, db_cap, db_clr, issue_hs;

  // rdy_en keeps both ready outputs low through reset and the first edge after it
  assign cmd_rdy  = rdy_en && (count < NUM);
  assign db_rdy   = rdy_en && !db_full;
  assign enq      = cmd_val && cmd_rdy;
  assign db_cap   = db_val && db_rdy;
  assign issue_hs = (state == ISSUE) && dma_rdy;
  assign deq      = issue_hs && !cur_debug;
  assign db_clr   = issue_hs && cur_debug;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (db_full || count != '0) state_nxt = ISSUE;
      ISSUE:    if (dma_rdy) state_nxt = WAIT_ACK;
      WAIT_ACK: if (dma_ack || timer == TLAST) state_nxt = RESP;
      RESP:     if (done_rdy) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  assign dma_val          = (state == ISSUE) && !cur_debug;
  assign dma_db_val       = (state == ISSUE) && cur_debug;
  assign dma_src_addr     = dma_val    ? cur_src  : '0;
  assign dma_dest_addr    = dma_val    ? cur_dest : '0;
  assign dma_db_src_addr  = dma_db_val ? cur_src  : '0;
  assign dma_db_dest_addr = dma_db_val ? cur_dest : '0;
  assign dma_db_inst      = dma_db_val && cur_inst;
  assign done_val         = (state == RESP);
  assign done_tag         = done_val ? cur_tag : '0;
  assign done_debug       = done_val && cur_debug;
  assign done_err         = done_val && err_q;
  assign done_data        = done_val ? data_q : '0;

  always_ff @(posedge clk) begin
    if (enq) begin
      q_src[wr_ptr]  <= cmd_src_addr;
      q_dest[wr_ptr] <= cmd_dest_addr;
      q_tag[wr_ptr]  <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      db_full   <= 1'b0;
      db_inst_q <= 1'b0;
      db_src_q  <= '0;
      db_dest_q <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (!enq && deq) count <= count - CW'(1);
      if (db_cap) begin
        db_full   <= 1'b1;
        db_src_q  <= db_src_addr;
        db_dest_q <= db_dest_addr;
        db_inst_q <= db_inst;
      end else if (db_clr) begin
        db_full <= 1'b0;
      end
    end
  end

  // Selection is latched in IDLE; the FIFO head stays put until the ISSUE handshake pops it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_debug <= 1'b0;
      cur_inst  <= 1'b0;
      cur_src   <= '0;
      cur_dest  <= '0;
      cur_tag   <= '0;
      timer     <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      if (state == IDLE) begin
        if (db_full) begin
          cur_debug <= 1'b1;
          cur_inst  <= db_inst_q;
          cur_src   <= db_src_q;
          cur_dest  <= db_dest_q;
          cur_tag   <= '0;
        end else if (count != '0) begin
          cur_debug <= 1'b0;
          cur_inst  <= 1'b0;
          cur_src   <= q_src[rd_ptr];
          cur_dest  <= q_dest[rd_ptr];
          cur_tag   <= q_tag[rd_ptr];
        end
      end
      if (state == WAIT_ACK) timer <= timer + TW'(1);
      else                   timer <= '0;
      if (state == WAIT_ACK) begin
        if (dma_ack) begin
          err_q  <= 1'b0;
          data_q <= (cur_debug && cur_inst) ? dma_debug_data : '0;
        end else if (timer == TLAST) begin
          err_q  <= 1'b1;
          data_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_plab5_mcore_dma_cmd_queue.sv
// Directed self-checking bench for plab5_mcore_dma_cmd_queue.
module tb_plab5_mcore_dma_cmd_queue;
  localparam int P_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_val = 1'b0, cmd_rdy;
  logic [31:0] cmd_src_addr = '0, cmd_dest_addr = '0;
  logic [3:0]  cmd_tag = '0;
  logic        db_val = 1'b0, db_rdy, db_inst = 1'b0;
  logic [31:0] db_src_addr = '0, db_dest_addr = '0;
  logic        dma_val, dma_db_val, dma_rdy = 1'b0, dma_db_inst, dma_ack = 1'b0;
  logic [31:0] dma_src_addr, dma_dest_addr, dma_db_src_addr, dma_db_dest_addr;
  logic [31:0] dma_debug_data = '0;
  logic        done_val, done_rdy = 1'b0, done_debug, done_err;
  logic [3:0]  done_tag;
  logic [31:0] done_data;

  int errors = 0;
  int checks = 0;

  plab5_mcore_dma_cmd_queue #(
    .p_addr_nbits(32), .p_data_nbits(32), .p_tag_nbits(4),
    .p_num_entries(4), .p_timeout(P_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_src_addr(cmd_src_addr),
    .cmd_dest_addr(cmd_dest_addr), .cmd_tag(cmd_tag),
    .db_val(db_val), .db_rdy(db_rdy), .db_src_addr(db_src_addr),
    .db_dest_addr(db_dest_addr), .db_inst(db_inst),
    .dma_val(dma_val), .dma_db_val(dma_db_val), .dma_rdy(dma_rdy),
    .dma_src_addr(dma_src_addr), .dma_dest_addr(dma_dest_addr),
    .dma_db_src_addr(dma_db_src_addr), .dma_db_dest_addr(dma_db_dest_addr),
    .dma_db_inst(dma_db_inst), .dma_ack(dma_ack), .dma_debug_data(dma_debug_data),
    .done_val(done_val), .done_rdy(done_rdy), .done_tag(done_tag),
    .done_debug(done_debug), .done_err(done_err), .done_data(done_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enqueue(input logic [31:0] s, input logic [31:0] d, input logic [3:0] tg);
    cmd_val = 1'b1; cmd_src_addr = s; cmd_dest_addr = d; cmd_tag = tg;
    tick();
    cmd_val = 1'b0;
  endtask

  task automatic wait_issue(output logic ok);
    int n = 0;
    while (!(dma_val || dma_db_val) && n < 50) begin tick(); n++; end
    ok = dma_val || dma_db_val;
  endtask

  // Drives one request through issue, ack and response; returns what was observed.
  task automatic complete_one(input logic [31:0] ack_data, output logic ok,
                              output logic is_db, output logic [31:0] s, output logic [31:0] d,
                              output logic inst, output logic other_zero,
                              output logic [3:0] tg, output logic dbg, output logic err,
                              output logic [31:0] data);
    logic seen;
    wait_issue(seen);
    is_db = dma_db_val;
    s     = is_db ? dma_db_src_addr  : dma_src_addr;
    d     = is_db ? dma_db_dest_addr : dma_dest_addr;
    inst  = dma_db_inst;
    other_zero = is_db ? (!dma_val && dma_src_addr == 0 && dma_dest_addr == 0)
                       : (!dma_db_val && dma_db_src_addr == 0 && dma_db_dest_addr == 0 && !dma_db_inst);
    tick();
    dma_ack = 1'b1; dma_debug_data = ack_data;
    tick();
    dma_ack = 1'b0; dma_debug_data = '0;
    ok  = seen && done_val;
    tg  = done_tag; dbg = done_debug; err = done_err; data = done_data;
    done_rdy = 1'b1;
    tick();
    done_rdy = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_cmd_rdy: got %b want 0", cmd_rdy); end
    checks++; if (db_rdy !== 1'b0) begin errors++; $display("FAIL rst_db_rdy: got %b want 0", db_rdy); end
    checks++; if ({dma_val, dma_db_val, done_val, done_data, dma_src_addr} !== '0) begin
      errors++; $display("FAIL rst_outputs: val/data not zero during reset"); end
    reset = 1'b1;
    #1;
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rel_cmd_rdy_early: got %b want 0", cmd_rdy); end
    tick();
    checks++; if (cmd_rdy !== 1'b1 || db_rdy !== 1'b1) begin
      errors++; $display("FAIL rel_rdy: got cmd %b db %b want 1 1", cmd_rdy, db_rdy); end
  endtask

  task automatic test_single;
    logic ok;
    dma_rdy = 1'b1;
    enqueue(32'h100, 32'h200, 4'd3);
    wait_issue(ok);
    checks++; if (!ok || dma_val !== 1'b1 || dma_db_val !== 1'b0) begin
      errors++; $display("FAIL single_issue: got val %b db %b want 1 0", dma_val, dma_db_val); end
    checks++; if (dma_src_addr !== 32'h100 || dma_dest_addr !== 32'h200) begin
      errors++; $display("FAIL single_addr: got %h/%h want 100/200", dma_src_addr, dma_dest_addr); end
    tick();
    checks++; if (dma_val !== 1'b0 || dma_src_addr !== 32'h0) begin
      errors++; $display("FAIL single_one_cycle: got val %b addr %h want 0 0", dma_val, dma_src_addr); end
    repeat (4) tick();
    checks++; if (done_val !== 1'b0) begin errors++; $display("FAIL single_early_done: got %b want 0", done_val); end
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    checks++; if (done_val !== 1'b1 || done_tag !== 4'd3 || done_err !== 1'b0 || done_data !== 32'h0 || done_debug !== 1'b0) begin
      errors++; $display("FAIL single_done: got val %b tag %0d err %b data %h dbg %b want 1 3 0 0 0",
                         done_val, done_tag, done_err, done_data, done_debug); end
    done_rdy = 1'b1; tick(); done_rdy = 1'b0;
    checks++; if (done_val !== 1'b0) begin errors++; $display("FAIL single_done_clear: got %b want 0", done_val); end
  endtask

  task automatic test_fill;
    logic ok, is_db, inst, oz, dbg, err;
    logic [31:0] s, d, data;
    logic [3:0] tg;
    dma_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (cmd_rdy !== (i < 4)) begin
        errors++; $display("FAIL fill_rdy_%0d: got %b want %b", i, cmd_rdy, (i < 4)); end
      cmd_val = 1'b1; cmd_tag = 4'(i); cmd_src_addr = 32'h1000 + i; cmd_dest_addr = 32'h2000 + i;
      tick();
    end
    cmd_val = 1'b0;
    checks++; if (cmd_rdy !== 1'b0 || dma_val !== 1'b1 || dma_src_addr !== 32'h1000) begin
      errors++; $display("FAIL fill_full: got rdy %b val %b src %h want 0 1 1000", cmd_rdy, dma_val, dma_src_addr); end
    dma_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      complete_one(32'h55, ok, is_db, s, d, inst, oz, tg, dbg, err, data);
      checks++; if (!ok || is_db || tg !== 4'(k) || s !== 32'h1000 + k || d !== 32'h2000 + k || err || data !== 0) begin
        errors++; $display("FAIL fill_order_%0d: got ok %b tag %0d src %h dest %h err %b data %h", k, ok, tg, s, d, err, data); end
    end
  endtask

  task automatic test_priority;
    logic ok, is_db, inst, oz, dbg, err;
    logic [31:0] s, d, data;
    logic [3:0] tg;
    dma_rdy = 1'b0;
    cmd_val = 1'b1; cmd_tag = 4'd5; cmd_src_addr = 32'h3000; cmd_dest_addr = 32'h3100;
    db_val = 1'b1; db_inst = 1'b0; db_src_addr = 32'h50; db_dest_addr = 32'h60;
    tick();
    db_val = 1'b0;
    cmd_tag = 4'd6; cmd_src_addr = 32'h3001; cmd_dest_addr = 32'h3101;
    tick();
    cmd_val = 1'b0;
    checks++; if (dma_db_val !== 1'b1 || dma_val !== 1'b0 || db_rdy !== 1'b0) begin
      errors++; $display("FAIL prio_select: got db_val %b val %b db_rdy %b want 1 0 0", dma_db_val, dma_val, db_rdy); end
    dma_rdy = 1'b1;
    complete_one(32'h1234_5678, ok, is_db, s, d, inst, oz, tg, dbg, err, data);
    checks++; if (!ok || !is_db || !oz || s !== 32'h50 || d !== 32'h60 || !dbg || tg !== 0 || data !== 0 || err) begin
      errors++; $display("FAIL prio_debug: got ok %b db %b oz %b src %h dest %h dbg %b tag %0d data %h err %b",
                         ok, is_db, oz, s, d, dbg, tg, data, err); end
    for (int k = 0; k < 2; k++) begin
      complete_one(32'h0, ok, is_db, s, d, inst, oz, tg, dbg, err, data);
      checks++; if (!ok || is_db || dbg || !oz || tg !== 4'(5 + k) || s !== 32'h3000 + k) begin
        errors++; $display("FAIL prio_normal_%0d: got ok %b dbg %b tag %0d src %h", k, ok, dbg, tg, s); end
    end
  endtask

  task automatic test_debug_read;
    logic ok, is_db, inst, oz, dbg, err;
    logic [31:0] s, d, data;
    logic [3:0] tg;
    dma_rdy = 1'b1;
    db_val = 1'b1; db_inst = 1'b1; db_src_addr = 32'h80; db_dest_addr = 32'h90;
    tick();
    db_val = 1'b0; db_inst = 1'b0;
    checks++; if (db_rdy !== 1'b0) begin errors++; $display("FAIL dbrd_slot_full: got %b want 0", db_rdy); end
    complete_one(32'hDEADBEEF, ok, is_db, s, d, inst, oz, tg, dbg, err, data);
    checks++; if (!ok || !is_db || !inst || s !== 32'h80 || data !== 32'hDEADBEEF || !dbg || tg !== 0 || err) begin
      errors++; $display("FAIL dbrd_done: got ok %b db %b inst %b src %h data %h dbg %b tag %0d err %b",
                         ok, is_db, inst, s, data, dbg, tg, err); end
    checks++; if (db_rdy !== 1'b1) begin errors++; $display("FAIL dbrd_slot_free: got %b want 1", db_rdy); end
  endtask

  task automatic test_ack_ignored;
    logic ok, is_db, inst, oz, dbg, err;
    logic [31:0] s, d, data;
    logic [3:0] tg;
    dma_ack = 1'b1; repeat (3) tick(); dma_ack = 1'b0;
    checks++; if (done_val !== 1'b0 || dma_val !== 1'b0) begin
      errors++; $display("FAIL ack_idle: got done %b val %b want 0 0", done_val, dma_val); end
    dma_rdy = 1'b0;
    enqueue(32'h700, 32'h710, 4'd7);
    tick();
    dma_ack = 1'b1; tick(); tick(); dma_ack = 1'b0;
    checks++; if (dma_val !== 1'b1 || done_val !== 1'b0) begin
      errors++; $display("FAIL ack_issue: got val %b done %b want 1 0", dma_val, done_val); end
    dma_rdy = 1'b1;
    complete_one(32'h0, ok, is_db, s, d, inst, oz, tg, dbg, err, data);
    checks++; if (!ok || tg !== 4'd7 || s !== 32'h700 || err) begin
      errors++; $display("FAIL ack_after: got ok %b tag %0d src %h err %b", ok, tg, s, err); end
  endtask

  task automatic test_timeout;
    logic ok;
    int n;
    dma_rdy = 1'b1;
    enqueue(32'h900, 32'h910, 4'd9);
    wait_issue(ok);
    tick();
    n = 0;
    while (!done_val && n < 300) begin tick(); n++; end
    checks++; if (!ok || n != P_TIMEOUT) begin
      errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, P_TIMEOUT); end
    checks++; if (done_err !== 1'b1 || done_data !== 32'h0 || done_tag !== 4'd9) begin
      errors++; $display("FAIL timeout_done: got err %b data %h tag %0d want 1 0 9", done_err, done_data, done_tag); end
    done_rdy = 1'b1; tick(); done_rdy = 1'b0;
    enqueue(32'hA00, 32'hA10, 4'd10);
    wait_issue(ok);
    tick();
    repeat (P_TIMEOUT - 1) tick();
    checks++; if (done_val !== 1'b0) begin errors++; $display("FAIL tmo_edge_early: got %b want 0", done_val); end
    dma_ack = 1'b1; dma_debug_data = 32'hABCD;
    tick();
    dma_ack = 1'b0; dma_debug_data = '0;
    checks++; if (done_val !== 1'b1 || done_err !== 1'b0 || done_data !== 32'h0 || done_tag !== 4'd10) begin
      errors++; $display("FAIL tmo_edge_ack: got val %b err %b data %h tag %0d want 1 0 0 10",
                         done_val, done_err, done_data, done_tag); end
    done_rdy = 1'b1; tick(); done_rdy = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic ok, seen;
    dma_rdy = 1'b1;
    enqueue(32'hB00, 32'hB10, 4'd11);
    wait_issue(ok);
    tick();
    for (int i = 0; i < 3; i++) begin
      cmd_val = 1'b1; cmd_tag = 4'(12 + i); cmd_src_addr = 32'hB01 + i; tick();
    end
    cmd_val = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (cmd_rdy !== 1'b0 || db_rdy !== 1'b0 || done_val !== 1'b0 || dma_val !== 1'b0) begin
      errors++; $display("FAIL mid_rst_assert: got cmd %b db %b done %b val %b want 0", cmd_rdy, db_rdy, done_val, dma_val); end
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++; if (cmd_rdy !== 1'b1 || db_rdy !== 1'b1) begin
      errors++; $display("FAIL mid_rst_rdy: got cmd %b db %b want 1 1", cmd_rdy, db_rdy); end
    dma_ack = 1'b1; tick(); dma_ack = 1'b0;
    seen = 1'b0;
    repeat (20) begin tick(); if (done_val || dma_val || dma_db_val) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_quiet: got activity %b want 0", seen); end
    dma_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_count_%0d: got rdy %b want 1", i, cmd_rdy); end
      cmd_val = 1'b1; cmd_tag = 4'(i); cmd_src_addr = 32'hC000 + i; tick();
    end
    cmd_val = 1'b0;
    checks++; if (cmd_rdy !== 1'b0 || dma_src_addr !== 32'hC000) begin
      errors++; $display("FAIL mid_rst_refill: got rdy %b src %h want 0 C000", cmd_rdy, dma_src_addr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_priority();
    test_debug_read();
    test_ack_ignored();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_dma_cmd_queue.md
PLAB5_MCORE_DMA_CMD_QUEUE -- requirements
Module: plab5_mcore_dma_cmd_queue

Interface
REQ-001 Parameters SHALL be:
- p_addr_nbits, 32, address width.
- p_data_nbits, 32, debug data width.
- p_tag_nbits, 4, command tag width.
- p_num_entries, 4, command FIFO depth (power of 2, at least 2).
- p_timeout, 255, maximum cycles to wait for ack.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_val  in  1  core copy command valid.
- cmd_rdy  out  1  FIFO can accept a command.
- cmd_src_addr  in  a  copy source address.
- cmd_dest_addr  in  a  copy destination address.
- cmd_tag  in  t  core tag, echoed on completion.
- db_val  in  1  debug request valid.
- db_rdy  out  1  debug slot empty.
- db_src_addr  in  a  debug source address.
- db_dest_addr  in  a  debug destination address.
- db_inst  in  1  1 = debug read, 0 = debug copy.
- dma_val  out  1  normal request to the DMA controller.
- dma_db_val  out  1  debug request to the DMA controller.
- dma_rdy  in  1  DMA controller idle.
- dma_src_addr  out  a  source address to DMA.
- dma_dest_addr  out  a  destination address to DMA.
- dma_db_src_addr  out  a  debug source address to DMA.
- dma_db_dest_addr  out  a  debug destination address to DMA.
- dma_db_inst  out  1  debug instruction type to DMA.
- dma_ack  in  1  DMA operation complete.
- dma_debug_data  in  d  DMA debug read result.
- done_val  out  1  completion valid.
- done_rdy  in  1  completion accepted.
- done_tag  out  t  tag of the completed command (0 for debug).
- done_debug  out  1  completion belongs to a debug request.
- done_err  out  1  completion was produced by timeout.
- done_data  out  d  debug read data (0 otherwise).

Function
REQ-003 The block SHALL buffer normal commands in a p_num_entries FIFO with a count register; cmd_rdy = (count < p_num_entries); enqueue on cmd_val && cmd_rdy.
REQ-004 Full FIFO: cmd_rdy SHALL be 0; a same-cycle dequeue SHALL NOT raise cmd_rdy in that cycle.
REQ-005 The block SHALL hold one debug slot; db_rdy = slot empty; capture on db_val && db_rdy.
REQ-006 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK and RESP, and SHALL reset to IDLE.
REQ-007 IDLE: if the debug slot is full, select debug; else if count > 0, select the FIFO head; else stay in IDLE. On a selection, go to ISSUE next cycle. Debug SHALL win over normal when both are present.
REQ-008 ISSUE: drive dma_val (normal) or dma_db_val (debug) with the selected addresses held stable. Go to WAIT_ACK on the cycle val && dma_rdy. The FIFO head SHALL pop (or the debug slot clear) on that same cycle.
REQ-009 Address outputs SHALL be driven 0 when the corresponding val is low.
REQ-010 WAIT_ACK: a cycle counter SHALL start at 0 and increment each cycle.
- On dma_ack: latch done_data = dma_debug_data if debug && dma_db_inst, else 0; set done_err = 0; go to RESP.
- If the counter reaches p_timeout without ack: set done_err = 1, done_data = 0, go to RESP.
- An ack on the timeout cycle SHALL take priority (done_err = 0).
REQ-011 RESP: done_val = 1 with tag, debug, err and data held stable. Go to IDLE on done_rdy. At most one operation SHALL be outstanding at the DMA controller.
REQ-012 Enqueues and debug captures SHALL proceed in every state, concurrently with FSM activity.
REQ-013 FIFO pointers SHALL wrap modulo p_num_entries. Count SHALL be updated by +1, -1 or 0 for enqueue-only, dequeue-only, or both-or-neither.
REQ-014 dma_ack received outside WAIT_ACK SHALL be ignored.

Reset
REQ-015 On reset low, the following SHALL clear asynchronously and hold while reset is low: state = IDLE, count = 0, pointers = 0, debug slot empty, timeout counter = 0.
REQ-016 While reset is low, all val and data outputs SHALL be 0 except cmd_rdy and db_rdy. cmd_rdy and db_rdy SHALL be 0 during reset and go to 1 on the first clock after reset goes high.
REQ-017 Reset asserted mid-operation SHALL discard all queued, debug and in-flight commands; no completion SHALL be produced for them.

Verification
REQ-018 Single command: enqueue src 0x100, dest 0x200, tag 3; dma_rdy = 1; ack 5 cycles after issue -> dma_val for exactly 1 cycle with 0x100/0x200, then done_val, tag 3, err 0, data 0.
REQ-019 Fill: 5 back-to-back commands with dma_rdy = 0 -> first 4 accepted, cmd_rdy = 0 on the 5th; release dma_rdy -> completions in order with tags 0,1,2,3.
REQ-020 Priority: FIFO holds 2 commands and db_val is captured while IDLE -> dma_db_val is issued first and the first completion has done_debug = 1.
REQ-021 Debug read: db_inst = 1, dma_debug_data = 0xDEADBEEF on ack -> done_data = 0xDEADBEEF, done_debug = 1.
REQ-022 Timeout: issue with dma_ack held 0 -> done_val with done_err = 1 exactly p_timeout cycles after entering WAIT_ACK.
REQ-023 Reset mid-WAIT_ACK with 3 queued -> after reset, count = 0, cmd_rdy = 1, and no done_val.
